// File: rtl/fnd_scan_ctrl.sv
// Scans a 16-bit value onto a 4-digit common-anode 7-segment display, one digit per slot,
// with a dark gap at the start of each slot and frame-synchronous loading of new data.
module fnd_scan_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  fnd_com,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);

  typedef enum logic {S_GAP, S_SHOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          frame_end;

  logic [15:0]   shadow, active;
  logic          pending;

  logic [3:0]    lead_zero;
  logic [3:0]    nib;
  logic [3:0]    com_nxt, bcd_nxt;
  logic          dp_n_nxt;

  // The slot counter runs 0..DIV-1 across both states, so a slot is always DIV cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    frame_end = 1'b0;
    case (state)
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (cnt == SLOT_LAST) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          frame_end = (idx == 2'd3);
        end
      end
      default: begin
        state_nxt = S_GAP;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_GAP;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // A strobe on the boundary cycle bypasses the shadow so it is never a frame late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= 16'h0000;
      active  <= 16'h0000;
      pending <= 1'b0;
    end else if (frame_end && data_valid) begin
      shadow  <= data_in;
      active  <= data_in;
      pending <= 1'b0;
    end else if (frame_end && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (data_valid) begin
      shadow  <= data_in;
      pending <= 1'b1;
    end
  end

  always_comb begin
    lead_zero[3] = (active[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] && (active[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] && (active[7:4] == 4'h0);
    lead_zero[0] = 1'b0;
  end

  always_comb begin
    case (idx_nxt)
      2'd0:    nib = active[3:0];
      2'd1:    nib = active[7:4];
      2'd2:    nib = active[11:8];
      default: nib = active[15:12];
    endcase
  end

  // Outputs are computed from the upcoming state so they change on the edge that enters it.
  always_comb begin
    com_nxt  = 4'b1111;
    bcd_nxt  = 4'hF;
    dp_n_nxt = 1'b1;
    if (state_nxt == S_SHOW) begin
      com_nxt[idx_nxt] = 1'b0;
      dp_n_nxt         = ~dp_mask[idx_nxt];
      if (!(blank_lz && lead_zero[idx_nxt])) bcd_nxt = nib;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fnd_com    <= 4'b1111;
      bcd        <= 4'hF;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      fnd_com    <= com_nxt;
      bcd        <= bcd_nxt;
      dp_n       <= dp_n_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with DIV=10, GAP_CYC=2: every cycle of each frame is compared.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        data_valid = 1'b0;
  logic [3:0]  dp_mask = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  fnd_com;
  logic        dp_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  fnd_scan_ctrl #(
    .CLK_HZ (1000),
    .SCAN_HZ(100),
    .GAP_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .dp_mask   (dp_mask),
    .blank_lz  (blank_lz),
    .bcd       (bcd),
    .fnd_com   (fnd_com),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 40-cycle frame starting just after a boundary; strobes are placed by cycle index
  // within the frame (39 = the boundary cycle). Compares {fnd_com, bcd, dp_n, frame_tick}.
  task automatic run_frame(input string name, input logic [15:0] exp_bcd, input logic [3:0] exp_dp,
                           input int st_a, input logic [15:0] da,
                           input int st_b, input logic [15:0] db);
    int         slot;
    int         pos;
    logic [3:0] e_com;
    logic [3:0] e_bcd;
    logic       e_dp;
    logic       e_ft;
    for (int t = 1; t <= 40; t++) begin
      if (t - 1 == st_a) begin
        data_in = da; data_valid = 1'b1;
      end else if (t - 1 == st_b) begin
        data_in = db; data_valid = 1'b1;
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      slot  = (t % 40) / 10;
      pos   = t % 10;
      e_com = 4'b1111;
      e_bcd = 4'hF;
      e_dp  = 1'b1;
      if (t < 40 && pos >= 2) begin
        e_com[slot] = 1'b0;
        e_bcd       = exp_bcd[slot*4 +: 4];
        e_dp        = ~exp_dp[slot];
      end
      e_ft = (t == 40);
      check($sformatf("%s t=%0d", name, t), {22'd0, fnd_com, bcd, dp_n, frame_tick},
            {22'd0, e_com, e_bcd, e_dp, e_ft});
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_com", {28'd0, fnd_com}, 32'h0000000F);
    check("rst_bcd", {28'd0, bcd}, 32'h0000000F);
    check("rst_dp", {31'd0, dp_n}, 32'd1);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);

    rst_n = 1'b1;
    run_frame("f0_zero", 16'h0000, 4'b0000, 5, 16'h1234, -1, 16'h0000);
    run_frame("f1_1234", 16'h1234, 4'b0000, 20, 16'h0045, -1, 16'h0000);

    blank_lz = 1'b1;
    run_frame("f2_lz0045", 16'hFF45, 4'b0000, 10, 16'h0000, -1, 16'h0000);
    run_frame("f3_lz0000", 16'hFFF0, 4'b0000, 3, 16'h0100, -1, 16'h0000);
    run_frame("f4_lz0100", 16'hF100, 4'b0000, 5, 16'hAAAA, 25, 16'h5555);

    blank_lz = 1'b0;
    run_frame("f5_5555", 16'h5555, 4'b0000, 10, 16'h1111, 39, 16'h9999);

    dp_mask = 4'b0100;
    run_frame("f6_9999_dp", 16'h9999, 4'b0100, -1, 16'h0000, -1, 16'h0000);

    // Asynchronous reset in the middle of digit 2's lit window
    repeat (24) @(posedge clk);
    #1;
    check("pre_rst_com", {28'd0, fnd_com}, 32'h0000000B);
    check("pre_rst_dp", {31'd0, dp_n}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_com", {28'd0, fnd_com}, 32'h0000000F);
    check("async_bcd", {28'd0, bcd}, 32'h0000000F);
    check("async_dp", {31'd0, dp_n}, 32'd1);
    @(posedge clk); #1;
    check("held_com", {28'd0, fnd_com}, 32'h0000000F);
    rst_n = 1'b1;
    run_frame("f7_after_rst", 16'h0000, 4'b0100, -1, 16'h0000, -1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
